// File: rtl/game_progress_tracker.sv
// Round-level game tracker: counts eaten food and pellets, keeps score, power timer and lives,
// and sequences IDLE/PLAY/DYING/WON/LOST from qualified tile reads and ghost collisions.
module game_progress_tracker #(
   parameter int NUM_FOOD     = 5,
   parameter int TILE_W       = 4,
   parameter int FOOD_CODE    = 2,
   parameter int POWER_CODE   = 3,
   parameter int FOOD_PTS     = 10,
   parameter int POWER_PTS    = 50,
   parameter int GHOST_PTS    = 200,
   parameter int POWER_CYCLES = 8,
   parameter int NUM_LIVES    = 3,
   parameter int DEATH_CYCLES = 4,
   parameter int SCORE_W      = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic                             tile_valid,
   input  logic [TILE_W-1:0]                tile_code,
   input  logic                             ghost_hit,
   output logic [$clog2(NUM_FOOD+1)-1:0]    food_count,
   output logic [SCORE_W-1:0]               score,
   output logic [$clog2(NUM_LIVES+1)-1:0]   lives,
   output logic                             power_active,
   output logic                             user_won,
   output logic                             user_lost,
   output logic [2:0]                       game_state
);

   localparam int FOOD_W  = $clog2(NUM_FOOD+1);
   localparam int LIVES_W = $clog2(NUM_LIVES+1);
   localparam int PWR_W   = $clog2(POWER_CYCLES+1);
   localparam int DEATH_W = $clog2(DEATH_CYCLES+1);
   localparam logic [32:0] SCORE_MAX = 33'((64'd1 << SCORE_W) - 64'd1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PLAY  = 3'd1,
      DYING = 3'd2,
      WON   = 3'd3,
      LOST  = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [FOOD_W-1:0]    food_q, food_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [LIVES_W-1:0]   lives_q, lives_d;
   logic [PWR_W-1:0]     power_q, power_d;
   logic [DEATH_W-1:0]   death_q, death_d;

   logic                 eat_food, eat_power, protected_hit, win;
   logic [32:0]          points, score_sum;
   logic [SCORE_W-1:0]   score_sat;

   // Protection is judged on the timer before this edge, so a same-cycle pellet never shields a hit.
   assign eat_food      = tile_valid && (tile_code == TILE_W'(FOOD_CODE));
   assign eat_power     = tile_valid && (tile_code == TILE_W'(POWER_CODE));
   assign protected_hit = ghost_hit && (power_q != '0);
   assign win           = eat_food && (food_q == FOOD_W'(NUM_FOOD - 1));

   assign points    = (eat_food      ? 33'(FOOD_PTS)  : 33'd0)
                    + (eat_power     ? 33'(POWER_PTS) : 33'd0)
                    + (protected_hit ? 33'(GHOST_PTS) : 33'd0);
   assign score_sum = 33'(score_q) + points;
   assign score_sat = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : score_sum[SCORE_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         food_q  <= '0;
         score_q <= '0;
         lives_q <= LIVES_W'(NUM_LIVES);
         power_q <= '0;
         death_q <= '0;
      end else begin
         food_q  <= food_d;
         score_q <= score_d;
         lives_q <= lives_d;
         power_q <= power_d;
         death_q <= death_d;
      end
   end

   always_comb begin
      state_d = state_q;
      food_d  = food_q;
      score_d = score_q;
      lives_d = lives_q;
      power_d = power_q;
      death_d = death_q;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = PLAY;
         end
         PLAY: begin
            score_d = score_sat;
            if (eat_food && (food_q != FOOD_W'(NUM_FOOD))) food_d = food_q + FOOD_W'(1);
            if (eat_power)            power_d = PWR_W'(POWER_CYCLES);
            else if (power_q != '0)   power_d = power_q - PWR_W'(1);
            // Completing the maze beats a simultaneous unprotected collision.
            if (win) begin
               state_d = WON;
            end else if (ghost_hit && (power_q == '0)) begin
               if (lives_q <= LIVES_W'(1)) begin
                  lives_d = '0;
                  state_d = LOST;
               end else begin
                  lives_d = lives_q - LIVES_W'(1);
                  death_d = DEATH_W'(DEATH_CYCLES);
                  power_d = '0;
                  state_d = DYING;
               end
            end
         end
         DYING: begin
            power_d = '0;
            if (death_q <= DEATH_W'(1)) begin
               death_d = '0;
               state_d = PLAY;
            end else begin
               death_d = death_q - DEATH_W'(1);
            end
         end
         WON, LOST: begin
            if (start) begin
               state_d = PLAY;
               food_d  = '0;
               score_d = '0;
               lives_d = LIVES_W'(NUM_LIVES);
               power_d = '0;
               death_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      game_state   = state_q;
      food_count   = food_q;
      score        = score_q;
      lives        = lives_q;
      power_active = (power_q != '0);
      user_won     = (state_q == WON);
      user_lost    = (state_q == LOST);
   end

endmodule

// File: tb/tb_game_progress_tracker.sv
// Directed and randomized bench for game_progress_tracker; a default instance and a 6-bit-score
// instance share the stimulus and are compared against a round-level reference model.
module tb_game_progress_tracker;

   localparam int NUM_FOOD = 5;
   localparam int N_LIVES  = 3;
   localparam int PWR_LEN  = 8;
   localparam int DIE_LEN  = 4;
   localparam int MAX16    = 65535;
   localparam int MAX6     = 63;
   localparam int S_IDLE = 0, S_PLAY = 1, S_DYING = 2, S_WON = 3, S_LOST = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, start, tile_valid, ghost_hit;
   logic [3:0] tile_code;

   logic [2:0]  food_count, food_count6;
   logic [15:0] score;
   logic [5:0]  score6;
   logic [1:0]  lives, lives6;
   logic        power_active, power_active6, user_won, user_won6, user_lost, user_lost6;
   logic [2:0]  game_state, game_state6;

   game_progress_tracker dut (
      .clk(clk), .reset(reset), .start(start), .tile_valid(tile_valid),
      .tile_code(tile_code), .ghost_hit(ghost_hit), .food_count(food_count),
      .score(score), .lives(lives), .power_active(power_active),
      .user_won(user_won), .user_lost(user_lost), .game_state(game_state)
   );

   game_progress_tracker #(.SCORE_W(6)) dut6 (
      .clk(clk), .reset(reset), .start(start), .tile_valid(tile_valid),
      .tile_code(tile_code), .ghost_hit(ghost_hit), .food_count(food_count6),
      .score(score6), .lives(lives6), .power_active(power_active6),
      .user_won(user_won6), .user_lost(user_lost6), .game_state(game_state6)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int m_state, m_food, m_score, m_score6, m_lives, m_power, m_death;

   function automatic void modelReset();
      m_state = S_IDLE; m_food = 0; m_score = 0; m_score6 = 0;
      m_lives = N_LIVES; m_power = 0; m_death = 0;
   endfunction

   // One clock of round rules; the power timer is read as it stood before the edge.
   function automatic void modelStep(bit st, bit tv, int code, bit gh);
      int  pts;
      bit  food, pel, won, shielded;
      pts = 0;
      food = tv && (code == 2);
      pel  = tv && (code == 3);
      shielded = (m_power > 0);
      case (m_state)
         S_IDLE: if (st) m_state = S_PLAY;
         S_WON, S_LOST: if (st) begin
            m_state = S_PLAY; m_food = 0; m_score = 0; m_score6 = 0;
            m_lives = N_LIVES; m_power = 0; m_death = 0;
         end
         S_PLAY: begin
            won = 0;
            if (food) begin
               m_food += 1; pts += 10;
               won = (m_food == NUM_FOOD);
            end
            if (pel) begin pts += 50; m_power = PWR_LEN; end
            else if (m_power > 0) m_power -= 1;
            if (gh && shielded) pts += 200;
            m_score  = (m_score + pts > MAX16) ? MAX16 : m_score + pts;
            m_score6 = (m_score6 + pts > MAX6) ? MAX6 : m_score6 + pts;
            if (won) m_state = S_WON;
            else if (gh && !shielded) begin
               if (m_lives == 1) begin m_lives = 0; m_state = S_LOST; end
               else begin
                  m_lives -= 1; m_state = S_DYING; m_death = DIE_LEN; m_power = 0;
               end
            end
         end
         S_DYING: begin
            m_power = 0;
            if (m_death == 1) begin m_death = 0; m_state = S_PLAY; end
            else m_death -= 1;
         end
         default: ;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
         $error("[TB] %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      check({tag, ".state"},  32'(game_state),   32'(m_state));
      check({tag, ".food"},   32'(food_count),   32'(m_food));
      check({tag, ".score"},  32'(score),        32'(m_score));
      check({tag, ".lives"},  32'(lives),        32'(m_lives));
      check({tag, ".power"},  32'(power_active), 32'(m_power > 0));
      check({tag, ".won"},    32'(user_won),     32'(m_state == S_WON));
      check({tag, ".lost"},   32'(user_lost),    32'(m_state == S_LOST));
      check({tag, ".score6"}, 32'(score6),       32'(m_score6));
      check({tag, ".state6"}, 32'(game_state6),  32'(m_state));
   endtask

   task automatic applyStimulus(input bit st, input bit tv, input int code, input bit gh);
      start = st; tile_valid = tv; tile_code = code[3:0]; ghost_hit = gh;
      @(posedge clk);
      modelStep(st, tv, code, gh);
      #1;
      start = 1'b0; tile_valid = 1'b0; ghost_hit = 1'b0;
   endtask

   task automatic applyReset();
      reset = 1'b1;
      @(posedge clk);
      modelReset();
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL timeout: observed no finish, expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      bit st, tv, gh;
      int code;
      reset = 1'b0; start = 1'b0; tile_valid = 1'b0; tile_code = 4'd0; ghost_hit = 1'b0;
      modelReset();

      applyReset(); checkOutput("reset");
      check("reset_lives", 32'(lives), 3);
      applyStimulus(0, 1, 2, 0); checkOutput("idle_ignore");
      applyStimulus(1, 0, 0, 0); checkOutput("start");
      check("start_state", 32'(game_state), 1);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 0, 2, 0); checkOutput("level");
      end
      check("level_food", 32'(food_count), 0);

      applyStimulus(0, 1, 3, 0); checkOutput("pellet");
      check("pellet_score", 32'(score), 50);
      for (int i = 1; i <= 2; i++) begin
         applyStimulus(0, 0, 0, 0); checkOutput("pwr_wait");
      end
      applyStimulus(0, 0, 0, 1); checkOutput("prot_hit");
      check("prot_score", 32'(score), 250);
      check("prot_lives", 32'(lives), 3);
      check("prot_score6", 32'(score6), 63);
      for (int i = 4; i <= 8; i++) begin
         applyStimulus(0, 0, 0, 0); checkOutput("pwr_tail");
         check("pwr_window", 32'(power_active), 32'(i < 8));
      end

      applyStimulus(0, 1, 3, 0); checkOutput("reload_a");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 0); checkOutput("reload_gap");
      end
      applyStimulus(0, 1, 3, 0); checkOutput("reload_b");
      for (int j = 1; j <= 8; j++) begin
         applyStimulus(0, 0, 0, 0); checkOutput("reload_tail");
         check("reload_window", 32'(power_active), 32'(j < 8));
      end
      check("reload_score", 32'(score), 350);

      applyStimulus(0, 0, 0, 1); checkOutput("hit1");
      check("hit1_lives", 32'(lives), 2);
      check("hit1_state", 32'(game_state), 2);
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(0, 1, 2, 1); checkOutput("dying");
         check("dying_state", 32'(game_state), (k < 4) ? 32'd2 : 32'd1);
      end
      check("dying_food", 32'(food_count), 0);

      applyStimulus(0, 1, 3, 1); checkOutput("pellet_hit");
      check("pellet_hit_lives", 32'(lives), 1);
      check("pellet_hit_power", 32'(power_active), 0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 0, 0, 0); checkOutput("dying2");
      end
      applyStimulus(0, 0, 0, 1); checkOutput("hit_last");
      check("lost_flag", 32'(user_lost), 1);
      check("lost_lives", 32'(lives), 0);
      applyStimulus(1, 0, 0, 0); checkOutput("restart");
      check("restart_lives", 32'(lives), 3);
      check("restart_score", 32'(score), 0);

      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1, 2, 0); checkOutput("food_pre");
      end
      applyStimulus(0, 1, 2, 1); checkOutput("win_hit");
      check("win_hit_state", 32'(game_state), 3);
      check("win_hit_lives", 32'(lives), 3);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 2, 0); checkOutput("post_win");
      end
      check("post_win_food", 32'(food_count), 5);

      applyStimulus(1, 0, 0, 0); checkOutput("restart2");
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(0, 1, 2, 0); checkOutput("eat");
         check("eat_food", 32'(food_count), 32'(i));
      end
      check("win_score", 32'(score), 50);
      check("win_flag", 32'(user_won), 1);

      applyReset(); checkOutput("rand_reset");
      for (int n = 0; n < 400; n++) begin
         st   = ($urandom_range(0, 15) == 0);
         tv   = $urandom_range(0, 1) == 1;
         code = $urandom_range(0, 4);
         gh   = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 199) == 0) applyReset();
         else applyStimulus(st, tv, code, gh);
         checkOutput("rand");
      end

      applyReset();
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 1); checkOutput("pre_mid_reset");
      check("pre_mid_reset_state", 32'(game_state), 2);
      applyReset(); checkOutput("mid_reset");
      check("mid_reset_state", 32'(game_state), 0);
      check("mid_reset_lives", 32'(lives), 3);
      check("mid_reset_score", 32'(score), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
